oam_line_scanner: RTL and testbench

Parametrised OAM search engine for the video pipeline. At the start of each visible line it reads every sprite's Y byte from OAM, selects the first `MAX_PER_LINE` sprites that cover the current line in 8x8 or 8x16 mode, and records their OAM indices and row offsets. The result list is read through a random-access port by the downstream pixel fetcher. It sits between the OAM storage and the sprite fetch stage, and is driven by the mode-2 timing of the LCD controller.

---
 rtl/oam_line_scanner.sv | 139 +++++++++++++
 tb/tb_oam_line_scanner.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/oam_line_scanner.sv
// Per-line OAM search: reads every sprite's Y byte, keeps the first MAX_PER_LINE
// sprites covering the latched line, and exposes {index, row} through a read port.
module oam_line_scanner #(
    parameter  int NUM_SPRITES  = 40,
    parameter  int MAX_PER_LINE = 10,
    parameter  int Y_OFFSET     = 16,
    localparam int IDX_W        = $clog2(NUM_SPRITES),
    localparam int SLOT_W       = $clog2(MAX_PER_LINE),
    localparam int CNT_W        = $clog2(MAX_PER_LINE + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [7:0]        line,
    input  logic              tall,
    output logic              oam_rd,
    output logic [IDX_W-1:0]  oam_idx,
    input  logic [7:0]        oam_y,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  count,
    output logic              overflow,
    input  logic [SLOT_W-1:0] sel_slot,
    output logic [IDX_W-1:0]  sel_sprite,
    output logic [3:0]        sel_row
);

    typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DRAIN} state_t;

    state_t             state_q;
    logic [7:0]         line_q;
    logic               tall_q;
    logic               oam_rd_q;
    logic [IDX_W-1:0]   oam_idx_q;
    logic               done_q;
    logic [CNT_W-1:0]   count_q;
    logic               overflow_q;
    logic               cmp_vld_q;
    logic [IDX_W-1:0]   cmp_idx_q;
    logic [IDX_W-1:0]   slot_idx_q [MAX_PER_LINE];
    logic [3:0]         slot_row_q [MAX_PER_LINE];

    logic [8:0]         tgt;
    logic [8:0]         y9;
    logic [8:0]         diff;
    logic               hit;

    // 9-bit compare so line + Y_OFFSET and oam_y + height never wrap.
    assign tgt  = {1'b0, line_q} + 9'(Y_OFFSET);
    assign y9   = {1'b0, oam_y};
    assign diff = tgt - y9;
    assign hit  = (y9 <= tgt) && (tgt < (y9 + (tall_q ? 9'd16 : 9'd8)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            line_q     <= '0;
            tall_q     <= 1'b0;
            oam_rd_q   <= 1'b0;
            oam_idx_q  <= '0;
            done_q     <= 1'b0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            cmp_vld_q  <= 1'b0;
            cmp_idx_q  <= '0;
            for (int i = 0; i < MAX_PER_LINE; i++) begin
                slot_idx_q[i] <= '0;
                slot_row_q[i] <= '0;
            end
        end else begin
            done_q    <= 1'b0;
            cmp_vld_q <= 1'b0;
            if (abort) begin
                state_q    <= S_IDLE;
                oam_rd_q   <= 1'b0;
                oam_idx_q  <= '0;
                count_q    <= '0;
                overflow_q <= 1'b0;
            end else begin
                if (cmp_vld_q && hit) begin
                    if (count_q < CNT_W'(MAX_PER_LINE)) begin
                        slot_idx_q[count_q[SLOT_W-1:0]] <= cmp_idx_q;
                        slot_row_q[count_q[SLOT_W-1:0]] <= diff[3:0];
                        count_q <= count_q + 1'b1;
                    end else begin
                        overflow_q <= 1'b1;
                    end
                end
                case (state_q)
                    S_IDLE: begin
                        if (start) begin
                            line_q     <= line;
                            tall_q     <= tall;
                            count_q    <= '0;
                            overflow_q <= 1'b0;
                            oam_rd_q   <= 1'b1;
                            oam_idx_q  <= '0;
                            state_q    <= S_SCAN;
                        end
                    end
                    S_SCAN: begin
                        cmp_vld_q <= 1'b1;
                        cmp_idx_q <= oam_idx_q;
                        if (oam_idx_q == IDX_W'(NUM_SPRITES - 1)) begin
                            oam_rd_q  <= 1'b0;
                            oam_idx_q <= '0;
                            state_q   <= S_DRAIN;
                        end else begin
                            oam_idx_q <= oam_idx_q + 1'b1;
                        end
                    end
                    S_DRAIN: begin
                        done_q  <= 1'b1;
                        state_q <= S_IDLE;
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign oam_rd   = oam_rd_q;
    assign oam_idx  = oam_idx_q;
    assign busy     = (state_q != S_IDLE);
    assign done     = done_q;
    assign count    = count_q;
    assign overflow = overflow_q;

    always_comb begin
        sel_sprite = '0;
        sel_row    = '0;
        if (int'(sel_slot) < MAX_PER_LINE) begin
            sel_sprite = slot_idx_q[sel_slot];
            sel_row    = slot_row_q[sel_slot];
        end
    end

endmodule

// File: tb/tb_oam_line_scanner.sv
// Directed bench for oam_line_scanner: single-sprite vector table plus
// hand-written overflow, ignored-start, abort and mid-scan reset sequences.
module tb_oam_line_scanner;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       abort;
    logic [7:0] line;
    logic       tall;
    logic       oam_rd;
    logic [5:0] oam_idx;
    logic [7:0] oam_y;
    logic       busy;
    logic       done;
    logic [3:0] count;
    logic       overflow;
    logic [3:0] sel_slot;
    logic [5:0] sel_sprite;
    logic [3:0] sel_row;

    int nerr = 0;
    int nchk = 0;

    logic [7:0] mem [40];

    // per-scan observations, indexed by cycle number (edge 0 = start sampled)
    int rd_cnt, busy_cnt, done_cnt, done_cyc, first_rd, last_rd;
    logic busy_tr [64];
    int   cnt_tr  [64];

    oam_line_scanner dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .abort     (abort),
        .line      (line),
        .tall      (tall),
        .oam_rd    (oam_rd),
        .oam_idx   (oam_idx),
        .oam_y     (oam_y),
        .busy      (busy),
        .done      (done),
        .count     (count),
        .overflow  (overflow),
        .sel_slot  (sel_slot),
        .sel_sprite(sel_sprite),
        .sel_row   (sel_row)
    );

    always #5 clk = ~clk;

    always @(posedge clk) oam_y <= mem[oam_idx];

    task automatic chk(input string name, input int act, input int exp);
        nchk++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, " busy"},     int'(busy),     0);
        chk({tag, " done"},     int'(done),     0);
        chk({tag, " oam_rd"},   int'(oam_rd),   0);
        chk({tag, " oam_idx"},  int'(oam_idx),  0);
        chk({tag, " count"},    int'(count),    0);
        chk({tag, " overflow"}, int'(overflow), 0);
        sel_slot = 4'd0;
        #1;
        chk({tag, " slot0 sprite"}, int'(sel_sprite), 0);
        chk({tag, " slot0 row"},    int'(sel_row),    0);
    endtask

    task automatic read_slot(input int s, output int spr, output int row);
        sel_slot = 4'(s);
        #1;
        spr = int'(sel_sprite);
        row = int'(sel_row);
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 40; i++) mem[i] = 8'd0;
    endtask

    // Runs 50 cycles after accepting start; extra start/abort/reset at given cycles (-1 = none).
    task automatic run_scan(input int ln, input int tl, input int start2_cyc,
                            input int abort_cyc, input int rst_cyc);
        rd_cnt = 0; busy_cnt = 0; done_cnt = 0; done_cyc = -1;
        first_rd = -1; last_rd = -1;
        @(negedge clk);
        line  = 8'(ln);
        tall  = tl[0];
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        line  = 8'hA5;
        tall  = ~tl[0];
        for (int cyc = 1; cyc < 50; cyc++) begin
            start = (cyc == start2_cyc);
            abort = (cyc == abort_cyc);
            if (cyc == rst_cyc) begin
                rst_n = 1'b0;
                #1;
                chk_reset_vals("midscan reset");
                #1;
                rst_n = 1'b1;
            end
            busy_tr[cyc] = busy;
            cnt_tr[cyc]  = int'(count);
            if (oam_rd) begin
                rd_cnt++;
                if (first_rd < 0) first_rd = cyc;
                last_rd = cyc;
            end
            if (busy) busy_cnt++;
            if (done) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = cyc;
            end
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        abort = 1'b0;
    endtask

    typedef struct {
        int ln;
        int tl;
        int idx;
        int y;
        int hit;
        int row;
    } vec_t;

    vec_t vecs [11];

    initial begin
        int spr, row;
        vecs[0]  = '{ln: 15,  tl: 1, idx: 7,  y: 16,  hit: 1, row: 15};
        vecs[1]  = '{ln: 15,  tl: 0, idx: 7,  y: 16,  hit: 0, row: 0};
        vecs[2]  = '{ln: 0,   tl: 0, idx: 2,  y: 8,   hit: 0, row: 0};
        vecs[3]  = '{ln: 0,   tl: 0, idx: 2,  y: 9,   hit: 1, row: 7};
        vecs[4]  = '{ln: 0,   tl: 0, idx: 0,  y: 16,  hit: 1, row: 0};
        vecs[5]  = '{ln: 0,   tl: 0, idx: 39, y: 17,  hit: 0, row: 0};
        vecs[6]  = '{ln: 100, tl: 0, idx: 39, y: 110, hit: 1, row: 6};
        vecs[7]  = '{ln: 100, tl: 0, idx: 20, y: 120, hit: 0, row: 0};
        vecs[8]  = '{ln: 143, tl: 1, idx: 0,  y: 150, hit: 1, row: 9};
        vecs[9]  = '{ln: 240, tl: 1, idx: 33, y: 250, hit: 1, row: 6};
        vecs[10] = '{ln: 255, tl: 0, idx: 11, y: 255, hit: 0, row: 0};

        rst_n = 1'b0; start = 1'b0; abort = 1'b0; line = 8'd0; tall = 1'b0;
        sel_slot = 4'd0;
        clear_mem();
        repeat (3) @(posedge clk);
        #1;
        chk_reset_vals("reset");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // all Y=0, line 0: nothing hits, exact read window and done timing
        run_scan(0, 0, -1, -1, -1);
        chk("empty done cycle", done_cyc, 42);
        chk("empty done pulses", done_cnt, 1);
        chk("empty oam_rd cycles", rd_cnt, 40);
        chk("empty first rd", first_rd, 1);
        chk("empty last rd", last_rd, 40);
        chk("empty busy cycles", busy_cnt, 41);
        chk("empty busy c41", int'(busy_tr[41]), 1);
        chk("empty count", int'(count), 0);
        chk("empty overflow", int'(overflow), 0);

        foreach (vecs[v]) begin
            clear_mem();
            mem[vecs[v].idx] = 8'(vecs[v].y);
            run_scan(vecs[v].ln, vecs[v].tl, -1, -1, -1);
            chk($sformatf("vec%0d done cycle", v), done_cyc, 42);
            chk($sformatf("vec%0d count", v), int'(count), vecs[v].hit);
            chk($sformatf("vec%0d overflow", v), int'(overflow), 0);
            if (vecs[v].hit != 0) begin
                read_slot(0, spr, row);
                chk($sformatf("vec%0d sprite", v), spr, vecs[v].idx);
                chk($sformatf("vec%0d row", v), row, vecs[v].row);
            end
        end

        // 12 hits at odd indices 3..25: first ten kept, overflow flagged
        clear_mem();
        for (int i = 0; i < 12; i++) mem[3 + 2 * i] = 8'd16;
        run_scan(0, 0, -1, -1, -1);
        chk("ovf done cycle", done_cyc, 42);
        chk("ovf count", int'(count), 10);
        chk("ovf overflow", int'(overflow), 1);
        for (int s = 0; s < 10; s++) begin
            read_slot(s, spr, row);
            chk($sformatf("ovf slot%0d sprite", s), spr, 3 + 2 * s);
            chk($sformatf("ovf slot%0d row", s), row, 0);
        end

        // five hits at 0..4 with a second start at cycle 10 that must be ignored
        clear_mem();
        for (int i = 0; i < 5; i++) mem[i] = 8'd16;
        run_scan(0, 0, 10, -1, -1);
        chk("restart done cycle", done_cyc, 42);
        chk("restart done pulses", done_cnt, 1);
        chk("restart oam_rd cycles", rd_cnt, 40);
        chk("restart count", int'(count), 5);

        // abort at cycle 20 after five hits have been counted
        run_scan(0, 0, -1, 20, -1);
        chk("abort count before", cnt_tr[20], 5);
        chk("abort busy c20", int'(busy_tr[20]), 1);
        chk("abort busy c21", int'(busy_tr[21]), 0);
        chk("abort count c21", cnt_tr[21], 0);
        chk("abort done pulses", done_cnt, 0);
        chk("abort overflow", int'(overflow), 0);

        // five hits at 10..14 on line 2 (row 2), reset at cycle 30, then rescan
        clear_mem();
        for (int i = 10; i < 15; i++) mem[i] = 8'd16;
        run_scan(2, 0, -1, -1, 30);
        chk("rst done pulses", done_cnt, 0);
        chk("rst busy after", int'(busy_tr[31]), 0);
        run_scan(2, 0, -1, -1, -1);
        chk("rescan done cycle", done_cyc, 42);
        chk("rescan count", int'(count), 5);
        for (int s = 0; s < 5; s++) begin
            read_slot(s, spr, row);
            chk($sformatf("rescan slot%0d sprite", s), spr, 10 + s);
            chk($sformatf("rescan slot%0d row", s), row, 2);
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
